game_flow_fsm: RTL
==================

Name: game_flow_fsm

Overview:
- Parametrised successor to the top-level game-flow state machine.
- Owns the registered {page, substage} state instead of taking it as an input.
- Adds menu/action cursors, START and DODGE phase timers, attack/death/win sequencing and player op-code issue.
- Sits between the keyboard decoder and the renderer/player/bullet blocks; `state` drives page selection in the VGA path.

Parameters:
- PAGE_W, 4, width of page field (state upper bits)
- SUB_W, 4, width of substage field (state lower bits)
- MENU_ITEMS, 3, menu cursor positions (0=start, 1=credit, 2=help)
- ACTION_ITEMS, 4, action cursor positions (0=fight, 1..3=act/item/mercy)
- START_CYCLES, 100, cycles spent in START before ACTION
- DODGE_CYCLES, 1000, cycles per DODGE phase
- TMR_W, 16, timer width; must hold max(START_CYCLES, DODGE_CYCLES)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- key  in  4  key code (0=none, 1=W, 2=D, 3=S, 4=A, 5=SPACE, 6=ESC)
- key_valid  in  1  one-cycle strobe qualifying key
- is_death  in  1  player HP reached zero (level)
- attack_done  in  1  one-cycle strobe, attack bar finished
- monster_dead  in  1  sampled with attack_done
- state  out  PAGE_W+SUB_W  {page, substage}
- player_instr  out  4  player op code, one-cycle pulses, else 0
- player_dir  out  4  key code accompanying MOV
- is_move  out  1  high with MOV

Behaviour:
- Clock, reset and output style:
  - One clock domain; reset is asynchronous and active-high.
  - All outputs registered; response appears the cycle after the input.
  - Reset values: state={MENU,0}, player_instr=0, player_dir=0, is_move=0, timer=0, cursors=0.
- Page codes: MENU=0001, GAMEOVER=0010, WIN=0011, START=1000, DODGE=1001, ATTACK=1010, ACTION=1011. Any other page goes to MENU next cycle.
- Op codes: IDG=0011 (end dodge), SDG=0100 (start dodge), MOV=0101. HPY/DPY/SHP reserved, never issued.
- Keys act only when key_valid=1. key=0 with key_valid is ignored.
- MENU: substage=cursor.
  - W decrements, S increments, modulo MENU_ITEMS with wrap (0-W -> MENU_ITEMS-1).
  - SPACE at cursor 0 -> START with timer cleared. SPACE at other cursors -> no change.
- START: timer counts up; at START_CYCLES-1 -> ACTION with cursor=0.
- ACTION: substage=cursor.
  - A decrements, D increments, wrap modulo ACTION_ITEMS.
  - SPACE at 0 -> ATTACK. SPACE at nonzero -> DODGE.
- ATTACK: waits for attack_done. monster_dead=1 -> WIN, else DODGE.
- DODGE:
  - Entry: SDG pulse, timer cleared.
  - W/A/S/D -> player_instr=MOV, is_move=1, player_dir=key for one cycle.
  - At timer=DODGE_CYCLES-1 -> ACTION with an IDG pulse.
- GAMEOVER, WIN: SPACE -> MENU with cursor 0.
- Priority: is_death (in START/DODGE/ATTACK/ACTION) -> GAMEOVER > timer expiry > attack_done > key.
  - A MOV coinciding with expiry or death is dropped.
- Reset mid-phase aborts immediately; no IDG is issued.
- Timer saturates at its terminal value; it never wraps.

Optional Feature:
- Macro: GAME_PAUSE_EN.
- Defined:
  - ESC in DODGE toggles pause; substage[SUB_W-1] mirrors the pause flag.
  - While paused the timer holds, W/A/S/D are ignored and is_death is still honoured.
  - Pause clears on leaving DODGE.
- Undefined: ESC is ignored everywhere and substage stays 0 in DODGE.

Decomposition:
- Shared include/package game_defs: page codes, key codes, op codes.
- Sub-module wrap_cursor (parameter N): inc/dec inputs, clear input, wrapping index output. Instanced for the menu and action cursors.

Test Plan:
- Reset then SPACE -> state=0x10 held, then 0x80 one cycle after SPACE. After START_CYCLES -> 0xB0.
- MENU: S,S,S -> substage 1,2,0. W from 0 -> 2. SPACE at 2 -> stays MENU.
- ACTION cursor 1 + SPACE -> 0x90, SDG pulse. D key -> MOV/is_move/player_dir=2 for one cycle. After DODGE_CYCLES -> 0xB0 with IDG.
- ACTION SPACE at 0 -> 0xA0. attack_done with monster_dead=1 -> 0x30. SPACE -> 0x10.
- is_death asserted in the same cycle as DODGE timer expiry and a W key -> 0x20, no MOV, no IDG.
- GAME_PAUSE_EN: ESC in DODGE -> substage 0x8, timer frozen for 500 cycles. ESC again resumes; expiry is delayed by exactly 500 cycles.

Source files
------------

// File: rtl/game_defs.sv
// Shared encodings for the game-flow path: page codes, key codes, player op codes.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package game_defs;

  // Page field of the {page, substage} state word
  typedef enum logic [3:0] {
    PG_MENU     = 4'b0001,
    PG_GAMEOVER = 4'b0010,
    PG_WIN      = 4'b0011,
    PG_START    = 4'b1000,
    PG_DODGE    = 4'b1001,
    PG_ATTACK   = 4'b1010,
    PG_ACTION   = 4'b1011
  } page_e;

  // Key codes delivered by the keyboard decoder
  typedef enum logic [3:0] {
    KEY_NONE  = 4'd0,
    KEY_W     = 4'd1,
    KEY_D     = 4'd2,
    KEY_S     = 4'd3,
    KEY_A     = 4'd4,
    KEY_SPACE = 4'd5,
    KEY_ESC   = 4'd6
  } key_e;

  // Player op codes; HPY/DPY/SHP exist on the player side but are never issued here
  typedef enum logic [3:0] {
    OP_NONE = 4'b0000,
    OP_IDG  = 4'b0011,
    OP_SDG  = 4'b0100,
    OP_MOV  = 4'b0101
  } op_e;

  // True for the four direction keys that move the player during DODGE
  function automatic logic is_move_key(input logic [3:0] k);
    return (k == KEY_W) || (k == KEY_D) || (k == KEY_S) || (k == KEY_A);
  endfunction

endpackage

// File: rtl/wrap_cursor.sv
// Menu/action cursor: wrapping index 0..N-1 stepped by inc/dec, forced to 0 by clr.
// Latency: idx updates one cycle after inc/dec/clr; idx_nxt exposes the value being loaded.
// Backpressure: none; every qualified request is applied in the cycle it arrives.
module wrap_cursor #(
  parameter int N = 3,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  output logic [W-1:0] idx,
  output logic [W-1:0] idx_nxt
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  // Next index: clear wins, then step with wrap at both ends
  always_comb begin
    idx_nxt = idx;
    if (clr) begin
      idx_nxt = '0;
    end else if (inc) begin
      idx_nxt = (idx == LAST) ? '0 : idx + W'(1);
    end else if (dec) begin
      idx_nxt = (idx == '0) ? LAST : idx - W'(1);
    end
  end

  // Index register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx <= '0;
    end else begin
      idx <= idx_nxt;
    end
  end

endmodule

// File: rtl/game_flow_fsm.sv
// Top-level game flow: owns {page, substage}, cursors, START/DODGE timers and player op issue.
// Latency: all outputs registered; each response appears the cycle after its input.
// Backpressure: none; key/attack strobes are consumed the cycle they arrive. Option: GAME_PAUSE_EN.
module game_flow_fsm
  import game_defs::*;
#(
  parameter int PAGE_W       = 4,
  parameter int SUB_W        = 4,
  parameter int MENU_ITEMS   = 3,
  parameter int ACTION_ITEMS = 4,
  parameter int START_CYCLES = 100,
  parameter int DODGE_CYCLES = 1000,
  parameter int TMR_W        = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              key,
  input  logic                    key_valid,
  input  logic                    is_death,
  input  logic                    attack_done,
  input  logic                    monster_dead,
  output logic [PAGE_W+SUB_W-1:0] state,
  output logic [3:0]              player_instr,
  output logic [3:0]              player_dir,
  output logic                    is_move
);

  localparam int MCW = (MENU_ITEMS > 1) ? $clog2(MENU_ITEMS) : 1;
  localparam int ACW = (ACTION_ITEMS > 1) ? $clog2(ACTION_ITEMS) : 1;

  localparam logic [PAGE_W-1:0] P_MENU     = PAGE_W'(PG_MENU);
  localparam logic [PAGE_W-1:0] P_GAMEOVER = PAGE_W'(PG_GAMEOVER);
  localparam logic [PAGE_W-1:0] P_WIN      = PAGE_W'(PG_WIN);
  localparam logic [PAGE_W-1:0] P_START    = PAGE_W'(PG_START);
  localparam logic [PAGE_W-1:0] P_DODGE    = PAGE_W'(PG_DODGE);
  localparam logic [PAGE_W-1:0] P_ATTACK   = PAGE_W'(PG_ATTACK);
  localparam logic [PAGE_W-1:0] P_ACTION   = PAGE_W'(PG_ACTION);

  localparam logic [TMR_W-1:0] START_LAST = TMR_W'(START_CYCLES - 1);
  localparam logic [TMR_W-1:0] DODGE_LAST = TMR_W'(DODGE_CYCLES - 1);

  logic [PAGE_W-1:0] page, page_nxt;
  logic [SUB_W-1:0]  sub, sub_nxt;
  logic [TMR_W-1:0]  timer, timer_nxt, tmr_inc;
  logic [3:0]        instr_nxt, dir_nxt;
  logic              move_nxt;
  logic              menu_inc, menu_dec, menu_clr;
  logic              act_inc, act_dec, act_clr;
  logic [MCW-1:0]    menu_idx, menu_nxt;
  logic [ACW-1:0]    act_idx, act_nxt;
  logic              pause, pause_nxt;

  assign state = {page, sub};

  // Timer never wraps: it parks at all-ones if a phase were ever to outlast it
  assign tmr_inc = (timer == '1) ? timer : timer + TMR_W'(1);

  wrap_cursor #(.N(MENU_ITEMS), .W(MCW)) u_menu_cur (
    .clk     (clk),
    .reset   (reset),
    .inc     (menu_inc),
    .dec     (menu_dec),
    .clr     (menu_clr),
    .idx     (menu_idx),
    .idx_nxt (menu_nxt)
  );

  wrap_cursor #(.N(ACTION_ITEMS), .W(ACW)) u_act_cur (
    .clk     (clk),
    .reset   (reset),
    .inc     (act_inc),
    .dec     (act_dec),
    .clr     (act_clr),
    .idx     (act_idx),
    .idx_nxt (act_nxt)
  );

`ifdef GAME_PAUSE_EN
  // Pause flag: ESC toggles it inside DODGE; anything that leaves DODGE drops it
  always_comb begin
    pause_nxt = 1'b0;
    if (page_nxt == P_DODGE) begin
      pause_nxt = pause ^ ((page == P_DODGE) && key_valid && (key == KEY_ESC));
    end
  end
`else
  assign pause     = 1'b0;
  assign pause_nxt = 1'b0;
`endif

  // State register: page, substage, phase timer and the registered player outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      page         <= P_MENU;
      sub          <= '0;
      timer        <= '0;
      player_instr <= OP_NONE;
      player_dir   <= '0;
      is_move      <= 1'b0;
`ifdef GAME_PAUSE_EN
      pause        <= 1'b0;
`endif
    end else begin
      page         <= page_nxt;
      sub          <= sub_nxt;
      timer        <= timer_nxt;
      player_instr <= instr_nxt;
      player_dir   <= dir_nxt;
      is_move      <= move_nxt;
`ifdef GAME_PAUSE_EN
      pause        <= pause_nxt;
`endif
    end
  end

  // Next page, timer and cursor requests; death beats expiry beats attack_done beats keys
  always_comb begin
    page_nxt  = page;
    timer_nxt = timer;
    menu_inc  = 1'b0;
    menu_dec  = 1'b0;
    menu_clr  = 1'b0;
    act_inc   = 1'b0;
    act_dec   = 1'b0;
    act_clr   = 1'b0;
    case (page)
      P_MENU: begin
        if (key_valid) begin
          if (key == KEY_W) begin
            menu_dec = 1'b1;
          end else if (key == KEY_S) begin
            menu_inc = 1'b1;
          end else if ((key == KEY_SPACE) && (menu_idx == '0)) begin
            page_nxt  = P_START;
            timer_nxt = '0;
          end
        end
      end
      P_START: begin
        if (is_death) begin
          page_nxt = P_GAMEOVER;
        end else if (timer == START_LAST) begin
          page_nxt = P_ACTION;
          act_clr  = 1'b1;
        end else begin
          timer_nxt = tmr_inc;
        end
      end
      P_ACTION: begin
        if (is_death) begin
          page_nxt = P_GAMEOVER;
        end else if (key_valid) begin
          if (key == KEY_A) begin
            act_dec = 1'b1;
          end else if (key == KEY_D) begin
            act_inc = 1'b1;
          end else if (key == KEY_SPACE) begin
            if (act_idx == '0) begin
              page_nxt = P_ATTACK;
            end else begin
              page_nxt  = P_DODGE;
              timer_nxt = '0;
            end
          end
        end
      end
      P_ATTACK: begin
        if (is_death) begin
          page_nxt = P_GAMEOVER;
        end else if (attack_done) begin
          if (monster_dead) begin
            page_nxt = P_WIN;
          end else begin
            page_nxt  = P_DODGE;
            timer_nxt = '0;
          end
        end
      end
      P_DODGE: begin
        if (is_death) begin
          page_nxt = P_GAMEOVER;
        end else if (!pause && (timer == DODGE_LAST)) begin
          page_nxt = P_ACTION;
          act_clr  = 1'b1;
        end else if (!pause) begin
          timer_nxt = tmr_inc;
        end
      end
      P_GAMEOVER, P_WIN: begin
        if (key_valid && (key == KEY_SPACE)) begin
          page_nxt = P_MENU;
          menu_clr = 1'b1;
        end
      end
      default: begin
        page_nxt  = P_MENU;
        menu_clr  = 1'b1;
        timer_nxt = '0;
      end
    endcase
  end

  // Next outputs: op pulses from page transitions, MOV only while DODGE continues unpaused
  always_comb begin
    instr_nxt = OP_NONE;
    dir_nxt   = '0;
    move_nxt  = 1'b0;
    sub_nxt   = '0;
    if ((page_nxt == P_DODGE) && (page != P_DODGE)) begin
      instr_nxt = OP_SDG;
    end else if ((page == P_DODGE) && (page_nxt == P_ACTION)) begin
      instr_nxt = OP_IDG;
    end else if ((page == P_DODGE) && (page_nxt == P_DODGE) && !pause &&
                 key_valid && is_move_key(key)) begin
      instr_nxt = OP_MOV;
      dir_nxt   = key;
      move_nxt  = 1'b1;
    end
    case (page_nxt)
      P_MENU:   sub_nxt = SUB_W'(menu_nxt);
      P_ACTION: sub_nxt = SUB_W'(act_nxt);
      P_DODGE:  sub_nxt[SUB_W-1] = pause_nxt;
      default:  sub_nxt = '0;
    endcase
  end

endmodule
